// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating burst accumulator for multiplier products
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W:0] ACC_MAX  = {1'b0, {ACC_W{1'b1}}};
    localparam logic [LEN_W:0] LEN_ONE  = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W:0]   len;
    logic [LEN_W:0]   cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf_q;
    logic [ACC_W:0]   sum;
    logic             beat;

    // One guard bit above the accumulator exposes the carry used for saturation.
    assign sum = {1'b0, acc} + (ACC_W+1)'(in_product);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                beat     = in_valid;
                if (in_valid && (cnt == len - LEN_ONE)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                len   <= (cfg_len == '0) ? LEN_FULL : {1'b0, cfg_len};
                cnt   <= '0;
                acc   <= '0;
                ovf_q <= 1'b0;
            end else if (beat) begin
                cnt <= cnt + LEN_ONE;
                if (sum > ACC_MAX) begin
                    acc   <= ACC_MAX[ACC_W-1:0];
                    ovf_q <= 1'b1;
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end
        end
    end

    assign acc_out = acc;
    assign ovf     = ovf_q;

endmodule
